morse_char_assembler: RTL

- Sits directly downstream of the Morse timing decoder and consumes its dot, dash, lg (letter gap) and wg (word gap) pulses.
- Accumulates dot/dash symbols into a code word and translates the completed code into 8-bit ASCII when a gap arrives.
- Queues characters in a small FIFO and presents them on a valid/ready interface for a display or UART stage.

---
 rtl/morse_char_assembler.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/morse_char_assembler.sv
// Morse dot/dash accumulator, code-to-ASCII lookup and output character FIFO.
// Define MORSE_DIGITS_EN to also decode the 5-symbol digit codes 0-9.
module morse_char_assembler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_SYMBOLS = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dot,
  input  logic       dash,
  input  logic       lg,
  input  logic       wg,
  input  logic       char_ready,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       overflow,
  output logic       busy
);

  localparam int LW = $clog2(MAX_SYMBOLS + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = MAX_SYMBOLS;

  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_SYMBOLS);
  localparam logic [LW-1:0] LEN_LONG = LW'(MAX_SYMBOLS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    PUSH_CHAR,
    PUSH_SPACE
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [LW-1:0] hold_len_q, hold_len_d;
  logic [PW-1:0] hold_pat_q, hold_pat_d;
  logic          word_end_q, word_end_d;
  logic [7:0]    ascii_q, ascii_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       sym;
  logic       sym_bit;
  logic       term;
  logic       push;
  logic       do_push;
  logic       pop;
  logic [7:0] push_data;
  logic [7:0] lut_code;
  logic       unused_pat;

  assign unused_pat = ^hold_pat_q;

  // First symbol sits in the MSB of the used field; dot=0, dash=1.
  always_comb begin
    lut_code = 8'h3F;
    case (hold_len_q)
      LW'(1): lut_code = hold_pat_q[0] ? 8'h54 : 8'h45;
      LW'(2): begin
        case (hold_pat_q[1:0])
          2'b00:   lut_code = 8'h49;
          2'b01:   lut_code = 8'h41;
          2'b10:   lut_code = 8'h4E;
          2'b11:   lut_code = 8'h4D;
          default: ;
        endcase
      end
      LW'(3): begin
        case (hold_pat_q[2:0])
          3'b000:  lut_code = 8'h53;
          3'b001:  lut_code = 8'h55;
          3'b010:  lut_code = 8'h52;
          3'b011:  lut_code = 8'h57;
          3'b100:  lut_code = 8'h44;
          3'b101:  lut_code = 8'h4B;
          3'b110:  lut_code = 8'h47;
          3'b111:  lut_code = 8'h4F;
          default: ;
        endcase
      end
      LW'(4): begin
        case (hold_pat_q[3:0])
          4'b0000: lut_code = 8'h48;
          4'b0001: lut_code = 8'h56;
          4'b0010: lut_code = 8'h46;
          4'b0100: lut_code = 8'h4C;
          4'b0110: lut_code = 8'h50;
          4'b0111: lut_code = 8'h4A;
          4'b1000: lut_code = 8'h42;
          4'b1001: lut_code = 8'h58;
          4'b1010: lut_code = 8'h43;
          4'b1011: lut_code = 8'h59;
          4'b1100: lut_code = 8'h5A;
          4'b1101: lut_code = 8'h51;
          default: ;
        endcase
      end
`ifdef MORSE_DIGITS_EN
      LW'(5): begin
        case (hold_pat_q[4:0])
          5'b11111: lut_code = 8'h30;
          5'b01111: lut_code = 8'h31;
          5'b00111: lut_code = 8'h32;
          5'b00011: lut_code = 8'h33;
          5'b00001: lut_code = 8'h34;
          5'b00000: lut_code = 8'h35;
          5'b10000: lut_code = 8'h36;
          5'b11000: lut_code = 8'h37;
          5'b11100: lut_code = 8'h38;
          5'b11110: lut_code = 8'h39;
          default:  ;
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    sym        = dot | dash;
    sym_bit    = dash;
    term       = (lg | wg) & (len_q != '0);
    state_d    = state_q;
    len_d      = len_q;
    pat_d      = pat_q;
    hold_len_d = hold_len_q;
    hold_pat_d = hold_pat_q;
    word_end_d = word_end_q;
    ascii_d    = ascii_q;
    ovf_d      = ovf_q | (dot & dash);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    push       = 1'b0;
    push_data  = ascii_q;

    if (term) begin
      // A code finished while the emitter is still working is lost.
      if (state_q == IDLE) begin
        hold_len_d = len_q;
        hold_pat_d = pat_q;
        word_end_d = wg;
      end else begin
        ovf_d = 1'b1;
      end
      len_d = sym ? LW'(1) : '0;
      pat_d = sym ? {{(PW-1){1'b0}}, sym_bit} : '0;
    end else if (sym) begin
      if (len_q < LEN_MAX) begin
        len_d = len_q + LW'(1);
        pat_d = {pat_q[PW-2:0], sym_bit};
      end else begin
        len_d = LEN_LONG;
      end
    end

    case (state_q)
      IDLE: begin
        if (term) state_d = LOOKUP;
      end
      LOOKUP: begin
        ascii_d = lut_code;
        if (hold_len_q > LEN_MAX) ovf_d = 1'b1;
        state_d = PUSH_CHAR;
      end
      PUSH_CHAR: begin
        push    = 1'b1;
        state_d = word_end_q ? PUSH_SPACE : IDLE;
      end
      PUSH_SPACE: begin
        push      = 1'b1;
        push_data = 8'h20;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pop     = (cnt_q != '0) & char_ready;
    do_push = push & ((cnt_q != CNT_FULL) | pop);
    if (push & ~do_push) ovf_d = 1'b1;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(do_push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      pat_q      <= '0;
      hold_len_q <= '0;
      hold_pat_q <= '0;
      word_end_q <= 1'b0;
      ascii_q    <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pat_q      <= pat_d;
      hold_len_q <= hold_len_d;
      hold_pat_q <= hold_pat_d;
      word_end_q <= word_end_d;
      ascii_q    <= ascii_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign char_valid = cnt_q != '0;
  assign char_code  = mem_q[rd_ptr_q];
  assign overflow   = ovf_q;
  assign busy       = (len_q != '0) | (state_q != IDLE);

endmodule
